// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared hold-level encoding, zero constants and FSM state encoding for the
// pipeline hold/flush scheduler.
package pipe_hold_ctrl_pkg;

  localparam int HOLD_W = 3;

  typedef logic [HOLD_W-1:0] hold_flag_t;

  localparam hold_flag_t HOLD_NONE = 3'd0;
  localparam hold_flag_t HOLD_PC   = 3'd1;
  localparam hold_flag_t HOLD_IF   = 3'd2;
  localparam hold_flag_t HOLD_ID   = 3'd3;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [4:0]  ZERO_REG  = 5'd0;

  typedef enum logic [1:0] {
    PHC_RUN   = 2'd0,
    PHC_FLUSH = 2'd1,
    PHC_LU    = 2'd2
  } phc_state_t;

  // Levels are ordered, so merging sources is a numeric maximum.
  function automatic hold_flag_t hold_max(input hold_flag_t a, input hold_flag_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source operands in ID.
// Purely combinational so a forwarding unit can reuse it later.
module hazard_detect
  import pipe_hold_ctrl_pkg::*;
(
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_re,
  input  logic       id_rs2_re,
  output logic       lu_hzd
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 never carries a dependency, so a load into x0 cannot cause a hazard.
  assign rs1_hit = id_rs1_re & (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_re & (id_rs2 == ex_rd);
  assign lu_hzd  = ex_load & (ex_rd != ZERO_REG) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central hold/flush scheduler: merges redirect, load-use, multi-cycle, bus and
// interrupt stall sources into one hold level and keeps flush/bubble timing.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int LU_CYCLES    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_re_i,
  input  logic        id_rs2_re_i,
  input  logic        mc_busy_i,
  input  logic        bus_hold_i,
  input  logic        int_hold_i,
  input  logic        int_assert_i,
  input  logic [31:0] int_addr_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LU_RELOAD    = 3'(LU_CYCLES - 1);
  localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);
  localparam bit         LU_MULTI     = (LU_CYCLES > 1);

  phc_state_t  state;
  phc_state_t  state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  logic [31:0] stall_cnt;

  logic        redirect;
  logic        lu_hzd;
  hold_flag_t  src_hold;
  hold_flag_t  fsm_hold;
  hold_flag_t  hold_raw;

  hazard_detect u_hazard_detect (
    .ex_load   (ex_load_i),
    .ex_rd     (ex_rd_i),
    .id_rs1    (id_rs1_i),
    .id_rs2    (id_rs2_i),
    .id_rs1_re (id_rs1_re_i),
    .id_rs2_re (id_rs2_re_i),
    .lu_hzd    (lu_hzd)
  );

  assign redirect = int_assert_i | jump_flag_i;

  always_comb begin
    src_hold = HOLD_NONE;
    if (bus_hold_i || int_hold_i) src_hold = hold_max(src_hold, HOLD_PC);
    if (redirect || lu_hzd || mc_busy_i) src_hold = hold_max(src_hold, HOLD_ID);
  end

  assign fsm_hold = (state != PHC_RUN) ? HOLD_ID : HOLD_NONE;
  assign hold_raw = hold_max(src_hold, fsm_hold);

  // Reset masks every combinational output so nothing leaks out during reset.
  assign hold_flag_o = rst ? HOLD_NONE : hold_raw;
  assign jump_flag_o = rst ? 1'b0 : redirect;
  assign jump_addr_o = rst ? ZERO_WORD : (int_assert_i ? int_addr_i : jump_addr_i);
  assign stall_cnt_o = stall_cnt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      PHC_RUN: begin
        if (redirect && FLUSH_MULTI) begin
          state_nxt = PHC_FLUSH;
          cnt_nxt   = FLUSH_RELOAD;
        end else if (!redirect && lu_hzd && LU_MULTI) begin
          state_nxt = PHC_LU;
          cnt_nxt   = LU_RELOAD;
        end
      end
      PHC_FLUSH, PHC_LU: begin
        // A redirect restarts the flush window from either hold state.
        if (redirect) begin
          state_nxt = FLUSH_MULTI ? PHC_FLUSH : PHC_RUN;
          cnt_nxt   = FLUSH_MULTI ? FLUSH_RELOAD : 3'd0;
        end else if (cnt <= 3'd1) begin
          state_nxt = PHC_RUN;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt   = cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = PHC_RUN;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PHC_RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating count of held cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= ZERO_WORD;
    end else if ((hold_flag_o != HOLD_NONE) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench: single-cycle vector table plus multi-cycle sequences on two
// instances (FLUSH=2/LU=1 and FLUSH=3/LU=2).
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        ex_load_i;
  logic [4:0]  ex_rd_i, id_rs1_i, id_rs2_i;
  logic        id_rs1_re_i, id_rs2_re_i;
  logic        mc_busy_i, bus_hold_i, int_hold_i, int_assert_i;
  logic [31:0] int_addr_i;

  logic [2:0]  hold_a, hold_b;
  logic        jf_a, jf_b;
  logic [31:0] ja_a, ja_b, sc_a, sc_b;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.FLUSH_CYCLES(2), .LU_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i), .mc_busy_i(mc_busy_i),
    .bus_hold_i(bus_hold_i), .int_hold_i(int_hold_i), .int_assert_i(int_assert_i),
    .int_addr_i(int_addr_i), .hold_flag_o(hold_a), .jump_flag_o(jf_a),
    .jump_addr_o(ja_a), .stall_cnt_o(sc_a)
  );

  pipe_hold_ctrl #(.FLUSH_CYCLES(3), .LU_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i), .mc_busy_i(mc_busy_i),
    .bus_hold_i(bus_hold_i), .int_hold_i(int_hold_i), .int_assert_i(int_assert_i),
    .int_addr_i(int_addr_i), .hold_flag_o(hold_b), .jump_flag_o(jf_b),
    .jump_addr_o(ja_b), .stall_cnt_o(sc_b)
  );

  typedef struct {
    string       name;
    logic        jf;
    logic [31:0] ja;
    logic        ld;
    logic [4:0]  rd, rs1, rs2;
    logic        re1, re2, mc, bus, ih, ia;
    logic [31:0] iaddr;
    logic [2:0]  e_hold;
    logic        e_jf;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input string nm, input logic jf, input logic [31:0] ja,
                              input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic re1, input logic re2,
                              input logic mc, input logic bus, input logic ih, input logic ia,
                              input logic [31:0] iaddr, input logic [2:0] eh,
                              input logic ejf, input logic [31:0] ea);
    vec_t v;
    v.name = nm; v.jf = jf; v.ja = ja; v.ld = ld; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.re1 = re1; v.re2 = re2; v.mc = mc; v.bus = bus; v.ih = ih; v.ia = ia;
    v.iaddr = iaddr; v.e_hold = eh; v.e_jf = ejf; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    jump_flag_i = 0; jump_addr_i = 0; ex_load_i = 0; ex_rd_i = 0; id_rs1_i = 0;
    id_rs2_i = 0; id_rs1_re_i = 0; id_rs2_re_i = 0; mc_busy_i = 0; bus_hold_i = 0;
    int_hold_i = 0; int_assert_i = 0; int_addr_i = 0;
  endtask

  task automatic apply(input vec_t v);
    jump_flag_i = v.jf; jump_addr_i = v.ja; ex_load_i = v.ld; ex_rd_i = v.rd;
    id_rs1_i = v.rs1; id_rs2_i = v.rs2; id_rs1_re_i = v.re1; id_rs2_re_i = v.re2;
    mc_busy_i = v.mc; bus_hold_i = v.bus; int_hold_i = v.ih; int_assert_i = v.ia;
    int_addr_i = v.iaddr;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    //               name          jf ja            ld rd rs1 rs2 re1 re2 mc bus ih ia iaddr          hold jf addr
    vt[0]  = mk("idle",        0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        3'd0, 0, 32'h0);
    vt[1]  = mk("lu_rs2",      0, 32'h0,        1, 5, 0, 5, 0, 1, 0, 0, 0, 0, 32'h0,        3'd3, 0, 32'h0);
    vt[2]  = mk("lu_rd0",      0, 32'h0,        1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,        3'd0, 0, 32'h0);
    vt[3]  = mk("lu_no_re",    0, 32'h0,        1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 32'h0,        3'd0, 0, 32'h0);
    vt[4]  = mk("lu_rs1",      0, 32'h0,        1, 7, 7, 3, 1, 1, 0, 0, 0, 0, 32'h0,        3'd3, 0, 32'h0);
    vt[5]  = mk("no_load",     0, 32'h0,        0, 7, 7, 7, 1, 1, 0, 0, 0, 0, 32'h0,        3'd0, 0, 32'h0);
    vt[6]  = mk("mc_busy",     0, 32'h0,        0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0,        3'd3, 0, 32'h0);
    vt[7]  = mk("bus_hold",    0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        3'd1, 0, 32'h0);
    vt[8]  = mk("int_hold",    0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        3'd1, 0, 32'h0);
    vt[9]  = mk("jump",        1, 32'h100,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        3'd3, 1, 32'h100);
    vt[10] = mk("int_prio",    1, 32'h200,      0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h8000_0004, 3'd3, 1, 32'h8000_0004);
    vt[11] = mk("addr_nojump", 0, 32'h200,      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        3'd1, 0, 32'h200);
    vt[12] = mk("int_alone",   0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40,       3'd3, 1, 32'h40);

    // Reset with active sources: outputs forced quiet, counter cleared.
    idle(); rst = 1; jump_flag_i = 1; mc_busy_i = 1; jump_addr_i = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_hold_a", 32'(hold_a), 32'd0);
      chk("rst_hold_b", 32'(hold_b), 32'd0);
      chk("rst_jf", 32'(jf_a), 32'd0);
      chk("rst_addr", ja_a, 32'h0);
      if (i > 0) chk("rst_stall", sc_a, 32'h0);
      @(negedge clk);
    end
    rst = 0; idle();

    // Single jump, FLUSH=2: hold for exactly 2 cycles, counted twice.
    jump_flag_i = 1; jump_addr_i = 32'h100; #1;
    chk("j_flag", 32'(jf_a), 32'd1);
    chk("j_addr", ja_a, 32'h100);
    chk("j_hold0", 32'(hold_a), 32'd3);
    @(negedge clk); idle(); #1;
    chk("j_hold1", 32'(hold_a), 32'd3);
    chk("j_jf1", 32'(jf_a), 32'd0);
    @(negedge clk); #1;
    chk("j_hold2", 32'(hold_a), 32'd0);
    chk("j_stall", sc_a, 32'd2);

    // Table of single-cycle vectors, each followed by drain cycles.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk); apply(vt[i]); #1;
      chk({vt[i].name, "_hold"}, 32'(hold_a), 32'(vt[i].e_hold));
      chk({vt[i].name, "_jf"}, 32'(jf_a), 32'(vt[i].e_jf));
      chk({vt[i].name, "_addr"}, ja_a, vt[i].e_addr);
      @(negedge clk); idle();
      repeat (3) @(negedge clk);
    end

    // Load-use: LU=1 gives one bubble, LU=2 gives two.
    do_reset();
    ex_load_i = 1; ex_rd_i = 5; id_rs2_i = 5; id_rs2_re_i = 1; #1;
    chk("lu_a0", 32'(hold_a), 32'd3);
    chk("lu_b0", 32'(hold_b), 32'd3);
    @(negedge clk); idle(); #1;
    chk("lu_a1", 32'(hold_a), 32'd0);
    chk("lu_b1", 32'(hold_b), 32'd3);
    @(negedge clk); #1;
    chk("lu_b2", 32'(hold_b), 32'd0);

    // Second jump one cycle into FLUSH=3 reloads: four held cycles.
    @(negedge clk);
    jump_flag_i = 1; jump_addr_i = 32'h300; #1;
    chk("rl_b0", 32'(hold_b), 32'd3);
    @(negedge clk); jump_addr_i = 32'h304; #1;
    chk("rl_b1", 32'(hold_b), 32'd3);
    @(negedge clk); idle(); #1;
    chk("rl_b2", 32'(hold_b), 32'd3);
    @(negedge clk); #1;
    chk("rl_b3", 32'(hold_b), 32'd3);
    @(negedge clk); #1;
    chk("rl_b4", 32'(hold_b), 32'd0);

    // Redirect during LU_STALL moves to a full FLUSH window.
    @(negedge clk);
    ex_load_i = 1; ex_rd_i = 9; id_rs1_i = 9; id_rs1_re_i = 1;
    @(negedge clk); idle(); jump_flag_i = 1; #1;
    chk("luj_b1", 32'(hold_b), 32'd3);
    @(negedge clk); idle(); #1;
    chk("luj_b2", 32'(hold_b), 32'd3);
    @(negedge clk); #1;
    chk("luj_b3", 32'(hold_b), 32'd3);
    @(negedge clk); #1;
    chk("luj_b4", 32'(hold_b), 32'd0);

    // Flush time keeps elapsing under a bus stall.
    @(negedge clk);
    jump_flag_i = 1;
    @(negedge clk); idle(); bus_hold_i = 1; #1;
    chk("bs_b1", 32'(hold_b), 32'd3);
    @(negedge clk); #1;
    chk("bs_b2", 32'(hold_b), 32'd3);
    @(negedge clk); #1;
    chk("bs_b3", 32'(hold_b), 32'd1);
    @(negedge clk); idle();

    // Saturation of the stall counter.
    do_reset();
    mc_busy_i = 1;
    force dut_a.stall_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut_a.stall_cnt;
    @(negedge clk); #1;
    chk("sat1", sc_a, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    chk("sat2", sc_a, 32'hFFFF_FFFF);
    mc_busy_i = 0;

    // Reset mid-FLUSH leaves no residual hold.
    @(negedge clk);
    jump_flag_i = 1;
    @(negedge clk); idle(); rst = 1; #1;
    chk("rf_rst_b", 32'(hold_b), 32'd0);
    @(negedge clk); rst = 0; #1;
    chk("rf_after_b", 32'(hold_b), 32'd0);
    chk("rf_after_a", 32'(hold_a), 32'd0);
    chk("rf_stall", sc_b, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
